// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the subordinate state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR1,
    ST_ERR2,
    ST_WRITE,
    ST_READ_REQ,
    ST_READ_CAP,
    ST_READ_WAIT
  } state_e;

endpackage

// File: rtl/ahb_sub_addr_check.sv
// Address-phase decode: legality check, word address and byte lanes.
module ahb_sub_addr_check
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 64
) (
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [2:0]            hsize_i,
  output logic                  err_o,
  output logic [ADDR_WIDTH-3:0] word_addr_o,
  output logic [3:0]            be_o
);

  localparam logic [31:0] DEPTH32 = 32'(MEM_DEPTH);

  logic [31:0] word_ext;

  assign word_addr_o = haddr_i[ADDR_WIDTH-1:2];
  assign word_ext    = 32'(haddr_i[ADDR_WIDTH-1:2]);

  // Flag oversize, misaligned and out-of-range accesses
  always_comb begin
    err_o = 1'b0;
    if (hsize_i > HSIZE_WORD)                                err_o = 1'b1;
    if ((hsize_i == HSIZE_HALF) && haddr_i[0])               err_o = 1'b1;
    if ((hsize_i == HSIZE_WORD) && (haddr_i[1:0] != 2'b00))  err_o = 1'b1;
    if (word_ext >= DEPTH32)                                 err_o = 1'b1;
  end

  // Byte lanes touched by the access
  always_comb begin
    be_o = '0;
    case (hsize_i)
      HSIZE_BYTE: be_o = 4'b0001 << haddr_i[1:0];
      HSIZE_HALF: be_o = haddr_i[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be_o = 4'b1111;
      default:    be_o = '0;
    endcase
  end

endmodule

// File: rtl/ahb_sram_sub.sv
// AHB-Lite subordinate fronting a single-port synchronous word SRAM,
// with configurable wait states and two-cycle ERROR responses.
module ahb_sram_sub
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-3:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-3:0] waddr_q, waddr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           hrdata_q, hrdata_d;

  logic                  chk_err;
  logic [ADDR_WIDTH-3:0] chk_waddr;
  logic [3:0]            chk_be;
  logic                  cnt_zero;
  logic                  accept;
  logic                  active_trans;
  logic                  hready_out;
  logic                  hresp_out;
  logic                  req;
  logic                  we;
  logic                  unused_hburst;

  // Burst type is accepted on the bus but addressing is per-beat from HADDR
  assign unused_hburst = ^HBURST;

  ahb_sub_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_addr_check (
    .haddr_i     (HADDR),
    .hsize_i     (HSIZE),
    .err_o       (chk_err),
    .word_addr_o (chk_waddr),
    .be_o        (chk_be)
  );

  assign cnt_zero     = (cnt_q == '0);
  assign accept       = HSEL && HREADY && hready_out;
  assign active_trans = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);

  // State, wait counter, registered address phase and read data
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      waddr_q  <= '0;
      be_q     <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      waddr_q  <= waddr_d;
      be_q     <= be_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Next state: every HREADYOUT-high cycle is a potential address-phase accept
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_zero ? cnt_q : cnt_q - 1'b1;
    waddr_d  = waddr_q;
    be_d     = be_q;
    hrdata_d = hrdata_q;
    if (state_q == ST_READ_CAP) hrdata_d = mem_rdata_i;
    case (state_q)
      ST_ERR1:     state_d = ST_ERR2;
      ST_READ_REQ: state_d = ST_READ_CAP;
      ST_READ_CAP: begin
        state_d = ST_READ_WAIT;
        cnt_d   = CNT_RELOAD;
      end
      default: ;
    endcase
    if (hready_out) begin
      cnt_d = CNT_RELOAD;
      if (accept && active_trans) begin
        waddr_d = chk_waddr;
        be_d    = chk_be;
        if (chk_err)     state_d = ST_ERR1;
        else if (HWRITE) state_d = ST_WRITE;
        else             state_d = ST_READ_REQ;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Per-state bus response and SRAM strobes
  always_comb begin
    hready_out = 1'b1;
    hresp_out  = HRESP_OKAY;
    req        = 1'b0;
    we         = 1'b0;
    case (state_q)
      ST_ERR1: begin
        hready_out = 1'b0;
        hresp_out  = HRESP_ERROR;
      end
      ST_ERR2:     hresp_out = HRESP_ERROR;
      ST_WRITE: begin
        hready_out = cnt_zero;
        req        = cnt_zero;
        we         = cnt_zero;
      end
      ST_READ_REQ: begin
        hready_out = 1'b0;
        req        = 1'b1;
      end
      ST_READ_CAP:  hready_out = 1'b0;
      ST_READ_WAIT: hready_out = cnt_zero;
      default: ;
    endcase
  end

  assign HREADYOUT   = hready_out;
  assign HRESP       = hresp_out;
  assign HRDATA      = hrdata_q;
  // Strobes are masked during reset so an abandoned final write beat never commits
  assign mem_req_o   = req && !ARESET;
  assign mem_we_o    = we && !ARESET;
  assign mem_be_o    = mem_req_o ? be_q : '0;
  assign mem_addr_o  = waddr_q;
  assign mem_wdata_o = HWDATA;

endmodule

// File: tb/tb_ahb_sram_sub.sv
// Self-checking bench: table of single transfers on a zero-wait instance,
// plus pipelined burst and reset-in-read sequences on a two-wait instance.
module tb_ahb_sram_sub;
  import ahb_pkg::*;

  localparam int AW    = 8;
  localparam int DEPTH = 48;

  typedef struct {
    int          inst;
    logic        wr;
    logic [7:0]  addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          cyc;
    logic        err;
    logic [5:0]  waddr;
    logic [3:0]  be;
    logic [31:0] rdata;
  } vec_t;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          hsel0, hsel2;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE, HBURST;
  logic [31:0]   HWDATA;
  logic          HREADY;

  logic          hro0, hresp0, req0, we0;
  logic [31:0]   hrdata0, wd0, rd0;
  logic [AW-3:0] maddr0;
  logic [3:0]    be0;
  logic          hro2, hresp2, req2, we2;
  logic [31:0]   hrdata2, wd2, rd2;
  logic [AW-3:0] maddr2;
  logic [3:0]    be2;

  int            sel;
  logic          s_hro, s_hresp, s_req, s_we;
  logic [31:0]   s_hrdata, s_wd;
  logic [AW-3:0] s_maddr;
  logic [3:0]    s_be;

  logic [31:0] mem0 [64];
  logic [31:0] mem2 [64];

  int   errors = 0;
  int   checks = 0;
  vec_t sb[$];
  vec_t vt[15];

  always #5 ACLK = ~ACLK;

  always_comb begin
    if (sel == 2) begin
      s_hro = hro2; s_hresp = hresp2; s_req = req2; s_we = we2;
      s_hrdata = hrdata2; s_wd = wd2; s_maddr = maddr2; s_be = be2;
    end else begin
      s_hro = hro0; s_hresp = hresp0; s_req = req0; s_we = we0;
      s_hrdata = hrdata0; s_wd = wd0; s_maddr = maddr0; s_be = be0;
    end
  end

  assign HREADY = s_hro;

  ahb_sram_sub #(.ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
    .ACLK(ACLK), .ARESET(ARESET), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(hro0), .HRESP(hresp0), .HRDATA(hrdata0), .mem_req_o(req0), .mem_we_o(we0),
    .mem_addr_o(maddr0), .mem_be_o(be0), .mem_wdata_o(wd0), .mem_rdata_i(rd0));

  ahb_sram_sub #(.ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .WAIT_STATES(2)) dut2 (
    .ACLK(ACLK), .ARESET(ARESET), .HSEL(hsel2), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(hro2), .HRESP(hresp2), .HRDATA(hrdata2), .mem_req_o(req2), .mem_we_o(we2),
    .mem_addr_o(maddr2), .mem_be_o(be2), .mem_wdata_o(wd2), .mem_rdata_i(rd2));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // SRAM models: one-cycle read latency, byte-lane writes
  always @(posedge ACLK) begin
    if (req0) begin
      if (we0) mem0[maddr0] <= merge(mem0[maddr0], wd0, be0);
      else     rd0 <= mem0[maddr0];
    end
    if (req2) begin
      if (we2) mem2[maddr2] <= merge(mem2[maddr2], wd2, be2);
      else     rd2 <= mem2[maddr2];
    end
  end

  function automatic vec_t mk(input int inst, input logic wr, input logic [7:0] addr,
                              input logic [2:0] size, input logic [31:0] wdata, input int cyc,
                              input logic err, input logic [5:0] waddr, input logic [3:0] be,
                              input logic [31:0] rdata);
    vec_t v;
    v.inst = inst; v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
    v.cyc = cyc; v.err = err; v.waddr = waddr; v.be = be; v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    hsel0 = 1'b0; hsel2 = 1'b0; HTRANS = HTRANS_IDLE; HADDR = '0;
    HWRITE = 1'b0; HSIZE = 3'd0; HBURST = 3'd0;
  endtask

  // One non-pipelined transfer; entered and left just after a rising edge
  task automatic do_xfer(input int idx, input vec_t v);
    vec_t        e;
    int          cyc, reqs, leaks, n;
    logic        acc, done, first_resp, last_resp, w;
    logic [5:0]  a;
    logic [3:0]  b;
    logic [31:0] rd;
    sel = v.inst;
    hsel0 = (v.inst == 0); hsel2 = (v.inst == 2);
    HTRANS = HTRANS_NONSEQ; HADDR = v.addr; HWRITE = v.wr; HSIZE = v.size; HBURST = 3'd0;
    sb.push_back(v);
    n = 0;
    do begin
      @(negedge ACLK); acc = s_hro;
      @(posedge ACLK); #1; n++;
    end while (!acc && n < 20);
    idle_bus();
    HWDATA = v.wdata;
    cyc = 0; reqs = 0; leaks = 0; done = 1'b0;
    first_resp = 1'b0; last_resp = 1'b0; w = 1'b0; a = '0; b = '0; rd = '0;
    while (!done && cyc < 20) begin
      @(negedge ACLK); cyc++;
      if (cyc == 1) first_resp = s_hresp;
      if (s_req) begin reqs++; a = s_maddr; b = s_be; w = s_we; end
      else if (s_be != 4'h0) leaks++;
      if (s_hro) begin done = 1'b1; last_resp = s_hresp; rd = s_hrdata; end
      @(posedge ACLK); #1;
    end
    e = sb.pop_front();
    chk($sformatf("v%0d.done", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d.cycles", idx), cyc, e.cyc);
    chk($sformatf("v%0d.resp_first", idx), 32'(first_resp), 32'(e.err));
    chk($sformatf("v%0d.resp_last", idx), 32'(last_resp), 32'(e.err));
    chk($sformatf("v%0d.reqs", idx), reqs, e.err ? 0 : 1);
    chk($sformatf("v%0d.be_idle", idx), leaks, 0);
    if (!e.err) begin
      chk($sformatf("v%0d.addr", idx), 32'(a), 32'(e.waddr));
      chk($sformatf("v%0d.be", idx), 32'(b), 32'(e.be));
      chk($sformatf("v%0d.we", idx), 32'(w), 32'(e.wr));
      if (!e.wr) chk($sformatf("v%0d.rdata", idx), rd, e.rdata);
    end
  endtask

  logic [7:0]  pa [5];
  logic        pw [5];
  logic [31:0] pd [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ai, di, dc, total, commits;
    logic rdy;
    vec_t rv;

    for (int i = 0; i < 64; i++) begin mem0[i] = '0; mem2[i] = '0; end
    sel = 0; HWDATA = '0; idle_bus();

    vt[0]  = mk(0, 1, 8'h10, 3'd2, 32'hDEADBEEF, 1, 0, 6'd4,  4'hF, 32'h0);
    vt[1]  = mk(0, 0, 8'h10, 3'd2, 32'h0,        3, 0, 6'd4,  4'hF, 32'hDEADBEEF);
    vt[2]  = mk(0, 1, 8'h13, 3'd0, 32'hAA000000, 1, 0, 6'd4,  4'h8, 32'h0);
    vt[3]  = mk(0, 0, 8'h10, 3'd2, 32'h0,        3, 0, 6'd4,  4'hF, 32'hAAADBEEF);
    vt[4]  = mk(0, 1, 8'h11, 3'd1, 32'h12345678, 2, 1, 6'd0,  4'h0, 32'h0);
    vt[5]  = mk(0, 1, 8'h12, 3'd1, 32'h12340000, 1, 0, 6'd4,  4'hC, 32'h0);
    vt[6]  = mk(0, 0, 8'h10, 3'd2, 32'h0,        3, 0, 6'd4,  4'hF, 32'h1234BEEF);
    vt[7]  = mk(0, 0, 8'h00, 3'd3, 32'h0,        2, 1, 6'd0,  4'h0, 32'h0);
    vt[8]  = mk(0, 1, 8'h02, 3'd2, 32'h0,        2, 1, 6'd0,  4'h0, 32'h0);
    vt[9]  = mk(0, 1, 8'hBC, 3'd2, 32'h55AA55AA, 1, 0, 6'd47, 4'hF, 32'h0);
    vt[10] = mk(0, 0, 8'hBC, 3'd2, 32'h0,        3, 0, 6'd47, 4'hF, 32'h55AA55AA);
    vt[11] = mk(0, 0, 8'hC0, 3'd2, 32'h0,        2, 1, 6'd0,  4'h0, 32'h0);
    vt[12] = mk(0, 1, 8'h05, 3'd0, 32'h00007700, 1, 0, 6'd1,  4'h2, 32'h0);
    vt[13] = mk(0, 1, 8'h06, 3'd1, 32'hBEEF0000, 1, 0, 6'd1,  4'hC, 32'h0);
    vt[14] = mk(0, 0, 8'h04, 3'd2, 32'h0,        3, 0, 6'd1,  4'hF, 32'hBEEF7700);

    // Reset state
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    @(negedge ACLK);
    chk("rst.hreadyout0", 32'(hro0), 32'd1);
    chk("rst.hresp0", 32'(hresp0), 32'd0);
    chk("rst.hrdata0", hrdata0, 32'd0);
    chk("rst.req0", 32'(req0), 32'd0);
    chk("rst.we0", 32'(we0), 32'd0);
    chk("rst.be0", 32'(be0), 32'd0);
    chk("rst.hreadyout2", 32'(hro2), 32'd1);
    chk("rst.hrdata2", hrdata2, 32'd0);
    @(posedge ACLK); #1;

    // IDLE and BUSY transfers: zero-wait OKAY, no SRAM access
    sel = 0; hsel0 = 1'b1; HADDR = 8'h10; HWRITE = 1'b1; HSIZE = 3'd2;
    for (int i = 0; i < 4; i++) begin
      HTRANS = (i < 2) ? HTRANS_IDLE : HTRANS_BUSY;
      @(negedge ACLK);
      chk($sformatf("idle%0d.hreadyout", i), 32'(hro0), 32'd1);
      chk($sformatf("idle%0d.hresp", i), 32'(hresp0), 32'd0);
      chk($sformatf("idle%0d.req", i), 32'(req0), 32'd0);
      @(posedge ACLK); #1;
    end
    idle_bus();

    // Table of single transfers on the zero-wait instance
    for (int i = 0; i < 15; i++) do_xfer(i, vt[i]);

    // Four-beat INCR write then back-to-back read of beat 0, two wait states
    sel = 2;
    pa = '{8'h20, 8'h24, 8'h28, 8'h2C, 8'h20};
    pw = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    pd = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3, 32'h0};
    ai = 0; di = -1; dc = 0; total = 0; commits = 0;
    for (int c = 0; c < 100 && (ai < 5 || di >= 0); c++) begin
      if (ai < 5) begin
        hsel2 = 1'b1; HADDR = pa[ai]; HWRITE = pw[ai]; HSIZE = 3'd2;
        HTRANS = (ai == 0 || ai == 4) ? HTRANS_NONSEQ : HTRANS_SEQ;
        HBURST = (ai < 4) ? 3'b011 : 3'b000;
      end else begin
        idle_bus();
      end
      if (di >= 0 && pw[di]) HWDATA = pd[di];
      @(negedge ACLK);
      if (di >= 0) begin dc++; total++; end
      if (s_req && s_we) begin
        if (commits < 4) begin
          chk($sformatf("burst.commit%0d.addr", commits), 32'(s_maddr), 32'(pa[commits] >> 2));
          chk($sformatf("burst.commit%0d.data", commits), s_wd, pd[commits]);
        end
        commits++;
      end
      rdy = s_hro;
      if (rdy && di >= 0) begin
        chk($sformatf("burst.beat%0d.cycles", di), dc, pw[di] ? 3 : 5);
        if (!pw[di]) begin
          rv = sb.pop_front();
          chk("burst.read.rdata", s_hrdata, rv.rdata);
          chk("burst.read.hresp", 32'(s_hresp), 32'd0);
        end
        dc = 0;
      end
      @(posedge ACLK); #1;
      if (rdy) begin
        if (ai == 4) sb.push_back(mk(2, 0, pa[0], 3'd2, 32'h0, 5, 0, 6'd8, 4'hF, pd[0]));
        di = (ai < 5) ? ai : -1;
        if (ai < 5) ai++;
      end
    end
    idle_bus();
    chk("burst.total_cycles", total, 17);
    chk("burst.commits", commits, 4);
    chk("burst.done", 32'(ai == 5 && di == -1), 32'd1);

    // Reset while in READ_WAIT abandons the read
    sel = 2; hsel2 = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 8'h24; HWRITE = 1'b0; HSIZE = 3'd2;
    @(posedge ACLK); #1;
    idle_bus();
    @(posedge ACLK);
    @(posedge ACLK); #1;
    chk("rstrd.in_wait", 32'(dut2.state_q), 32'(ST_READ_WAIT));
    chk("rstrd.hrdata_loaded", hrdata2, 32'hB1B1B1B1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("rstrd.hreadyout", 32'(hro2), 32'd1);
    chk("rstrd.hrdata", hrdata2, 32'd0);
    chk("rstrd.hresp", 32'(hresp2), 32'd0);
    chk("rstrd.state", 32'(dut2.state_q), 32'(ST_IDLE));
    @(posedge ACLK); #1;
    do_xfer(100, mk(2, 0, 8'h24, 3'd2, 32'h0, 5, 0, 6'd9, 4'hF, 32'hB1B1B1B1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_sram_sub.md
Name: ahb_sram_sub

Overview:
AHB-Lite subordinate that terminates the AHB bus driven by the team's AXI-to-AHB bridge. It decodes address and control phases and drives a single-port synchronous word SRAM. It inserts a configurable number of wait states and returns two-cycle ERROR responses for illegal accesses. This is the responder end used to close the loop in bridge-level simulation and on the small on-chip memory.

Parameters:
ADDR_WIDTH, 8, HADDR width in bits; must match the bridge's address width.
MEM_DEPTH, 64, number of 32-bit words backed; must be <= 2^(ADDR_WIDTH-2).
WAIT_STATES, 0, extra HREADYOUT-low cycles added to every read and write data phase (0..15).

Ports:
ACLK  in  1  clock; all logic is on the rising edge.
ARESET  in  1  synchronous, active-high reset.
HSEL  in  1  subordinate select.
HADDR  in  ADDR_WIDTH  byte address (address phase).
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
HWRITE  in  1  1=write.
HSIZE  in  3  transfer size; 0, 1 and 2 are legal.
HBURST  in  3  burst type; sampled but not used for addressing.
HWDATA  in  32  write data (data phase).
HREADY  in  1  bus-wide ready.
HREADYOUT  out  1  subordinate ready.
HRESP  out  1  0=OKAY, 1=ERROR.
HRDATA  out  32  read data, registered.
mem_req_o  out  1  SRAM access strobe, one cycle.
mem_we_o  out  1  1=write.
mem_addr_o  out  ADDR_WIDTH-2  word address.
mem_be_o  out  4  byte enables.
mem_wdata_o  out  32  write data.
mem_rdata_i  in  32  SRAM read data, valid the cycle after a read mem_req_o.

Behaviour:
- Reset (ARESET=1 at an edge): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0. mem_req_o, mem_we_o and mem_be_o are 0. Reset mid-transfer abandons the transfer, and no SRAM write is issued.
- Address phase is accepted at an edge when HSEL && HREADY. HADDR, HWRITE and HSIZE are registered at that edge.
  - HTRANS NONSEQ or SEQ: start a data phase.
  - HTRANS IDLE or BUSY: zero-wait OKAY response; state stays IDLE.
- Error check is done on the address phase. An access is an error if any of the following holds; errors never touch the SRAM:
  - HSIZE > 2;
  - HSIZE=1 with HADDR[0]=1;
  - HSIZE=2 with HADDR[1:0] != 0;
  - HADDR[ADDR_WIDTH-1:2] >= MEM_DEPTH.
- States and timing (Dn = nth data-phase cycle, D0 is the first):
  - IDLE: HREADYOUT=1, HRESP=0.
  - ERR1 then ERR2: ERR1 drives HREADYOUT=0, HRESP=1. ERR2 drives HREADYOUT=1, HRESP=1. Always exactly 2 cycles.
  - WRITE: D0..D(WAIT_STATES). HREADYOUT=0 except in the last cycle. In the last cycle: mem_req_o=1, mem_we_o=1, mem_wdata_o=HWDATA (passed through combinationally), HREADYOUT=1.
  - READ_REQ, READ_CAP, READ_WAIT:
    - D0 drives mem_req_o=1, mem_we_o=0.
    - D1 loads HRDATA from mem_rdata_i at its closing edge.
    - READ_WAIT lasts WAIT_STATES+1 cycles; HREADYOUT=1 only in its last cycle.
    - Total read data phase = WAIT_STATES+3 cycles.
  - HRDATA holds its value outside READ_CAP loads.
- mem_addr_o and mem_be_o come from the registered address phase.
  - Byte enables: size0 gives 1 bit at addr[1:0]; size1 gives 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1); size2 gives 4'b1111.
  - mem_be_o=0 whenever mem_req_o=0.
- Pipelining: a new address phase is only accepted in a cycle where HREADYOUT=1 (the final data-phase cycle, ERR2, or IDLE).
  - Acceptance in a final cycle goes directly to the next D0 with no idle gap.
  - Otherwise the block returns to IDLE.
- Read-after-write to the same word returns the new data: the write commits at the last write cycle, and the read request follows it.
- The wait counter is sized for WAIT_STATES+1 and reloads on every state entry.

Decomposition:
- Package ahb_pkg holds the HTRANS codes, HSIZE codes, HRESP OKAY/ERROR, and the state enum.
- One combinational sub-module, ahb_sub_addr_check, takes HADDR and HSIZE and produces the error flag, word address and byte enables.

Test Plan:
1. WAIT_STATES=0, single word write: NONSEQ write to 0x10 with HWDATA=0xDEADBEEF. Required: 1-cycle data phase; mem_req_o/mem_we_o high once with mem_addr_o=4 and mem_be_o=4'hF.
2. Read back 0x10. Required: HREADYOUT low for 2 cycles, then high with HRDATA=0xDEADBEEF and HRESP=0.
3. Byte write, HSIZE=0, to 0x13 with data 0xAA000000. Required: mem_be_o=4'b1000.
4. Halfword write, HSIZE=1, to 0x11. Required: ERR1/ERR2 (HREADYOUT 0 then 1, HRESP=1 both cycles) and no mem_req_o.
5. WAIT_STATES=2, 4-beat INCR write followed by a back-to-back read of beat 0. Required:
   - each write beat is 3 cycles;
   - the read returns the beat-0 data with no idle gap between transfers.
6. Reset mid-read: ARESET asserted in READ_WAIT. Required: the next cycle shows HREADYOUT=1, HRDATA=0, state IDLE, and a following read works normally.
